// File: rtl/rpsc_hv_sequencer.sv
// High-voltage power sequencer: ramps G1 then anode supplies, watches the
// interlock and supply health, and latches the first fault cause until acknowledged.
module rpsc_hv_sequencer #(
  parameter int unsigned CNT_WIDTH  = 22,
  parameter int unsigned G1_TIMEOUT = 1562500,
  parameter int unsigned AN_TIMEOUT = 3125000,
  parameter int unsigned OFF_DELAY  = 781250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       interlock_ok,
  input  logic       g1_ok,
  input  logic       an_ok,
  input  logic       fault_clr,
  output logic       g1_en,
  output logic       an_en,
  output logic       running,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [2:0] state
);

  localparam int unsigned CODE_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_G1_RAMP  = 3'd1,
    ST_AN_RAMP  = 3'd2,
    ST_RUN      = 3'd3,
    ST_SHUTDOWN = 3'd4,
    ST_FAULT    = 3'd5
  } state_e;

  localparam logic [CODE_W-1:0] FC_NONE      = 3'b000;
  localparam logic [CODE_W-1:0] FC_INTERLOCK = 3'b001;
  localparam logic [CODE_W-1:0] FC_G1_TMO    = 3'b010;
  localparam logic [CODE_W-1:0] FC_AN_TMO    = 3'b011;
  localparam logic [CODE_W-1:0] FC_G1_LOSS   = 3'b100;
  localparam logic [CODE_W-1:0] FC_AN_LOSS   = 3'b101;
  localparam logic [CODE_W-1:0] FC_BAD_STATE = 3'b111;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] G1_LAST  = CNT_WIDTH'(G1_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] AN_LAST  = CNT_WIDTH'(AN_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] OFF_LAST = CNT_WIDTH'(OFF_DELAY - 1);

  state_e              state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CODE_W-1:0]    fault_code_q, fault_code_d;
  logic                 g1_en_q, g1_en_d;
  logic                 an_en_q, an_en_d;
  logic                 running_q, running_d;
  logic                 fault_q, fault_d;

  // Next state follows the priority interlock > supply loss > stop > ok > timeout.
  always_comb begin
    state_d      = state_q;
    fault_code_d = fault_code_q;
    case (state_q)
      ST_IDLE: begin
        if (start && interlock_ok) state_d = ST_G1_RAMP;
      end
      ST_G1_RAMP: begin
        if (!interlock_ok) begin
          state_d = ST_FAULT; fault_code_d = FC_INTERLOCK;
        end else if (stop) begin
          state_d = ST_SHUTDOWN;
        end else if (g1_ok) begin
          state_d = ST_AN_RAMP;
        end else if (cnt_q >= G1_LAST) begin
          state_d = ST_FAULT; fault_code_d = FC_G1_TMO;
        end
      end
      ST_AN_RAMP: begin
        if (!interlock_ok) begin
          state_d = ST_FAULT; fault_code_d = FC_INTERLOCK;
        end else if (!g1_ok) begin
          state_d = ST_FAULT; fault_code_d = FC_G1_LOSS;
        end else if (stop) begin
          state_d = ST_SHUTDOWN;
        end else if (an_ok) begin
          state_d = ST_RUN;
        end else if (cnt_q >= AN_LAST) begin
          state_d = ST_FAULT; fault_code_d = FC_AN_TMO;
        end
      end
      ST_RUN: begin
        if (!interlock_ok) begin
          state_d = ST_FAULT; fault_code_d = FC_INTERLOCK;
        end else if (!g1_ok) begin
          state_d = ST_FAULT; fault_code_d = FC_G1_LOSS;
        end else if (!an_ok) begin
          state_d = ST_FAULT; fault_code_d = FC_AN_LOSS;
        end else if (stop) begin
          state_d = ST_SHUTDOWN;
        end
      end
      ST_SHUTDOWN: begin
        if (!interlock_ok) begin
          state_d = ST_FAULT; fault_code_d = FC_INTERLOCK;
        end else if (cnt_q >= OFF_LAST) begin
          state_d = ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (fault_clr && interlock_ok) begin
          state_d = ST_IDLE; fault_code_d = FC_NONE;
        end
      end
      default: begin
        state_d = ST_FAULT; fault_code_d = FC_BAD_STATE;
      end
    endcase

    // Phase counter restarts on every state change and saturates rather than wrapping.
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == ST_G1_RAMP || state_q == ST_AN_RAMP ||
                  state_q == ST_SHUTDOWN) && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    g1_en_d   = (state_d == ST_G1_RAMP) || (state_d == ST_AN_RAMP) ||
                (state_d == ST_RUN) || (state_d == ST_SHUTDOWN);
    an_en_d   = (state_d == ST_AN_RAMP) || (state_d == ST_RUN);
    running_d = (state_d == ST_RUN);
    fault_d   = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      fault_code_q <= FC_NONE;
      g1_en_q      <= 1'b0;
      an_en_q      <= 1'b0;
      running_q    <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fault_code_q <= fault_code_d;
      g1_en_q      <= g1_en_d;
      an_en_q      <= an_en_d;
      running_q    <= running_d;
      fault_q      <= fault_d;
    end
  end

  assign g1_en      = g1_en_q;
  assign an_en      = an_en_q;
  assign running    = running_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign state      = state_q;

endmodule

// File: tb/tb_rpsc_hv_sequencer.sv
// Bench for rpsc_hv_sequencer: directed sequences plus random stimulus, with a
// per-cycle expected-output queue fed from a behavioural model.
module tb_rpsc_hv_sequencer;

  localparam int unsigned G1T = 8;
  localparam int unsigned ANT = 15;
  localparam int unsigned OFD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0, stop = 1'b0, interlock_ok = 1'b1;
  logic       g1_ok = 1'b0, an_ok = 1'b0, fault_clr = 1'b0;
  logic       g1_en, an_en, running, fault;
  logic [2:0] fault_code, state;

  rpsc_hv_sequencer #(
    .CNT_WIDTH(22), .G1_TIMEOUT(G1T), .AN_TIMEOUT(ANT), .OFF_DELAY(OFD)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .interlock_ok(interlock_ok), .g1_ok(g1_ok), .an_ok(an_ok),
    .fault_clr(fault_clr), .g1_en(g1_en), .an_en(an_en), .running(running),
    .fault(fault), .fault_code(fault_code), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Expected outputs packed as {state, g1_en, an_en, running, fault, fault_code}.
  logic [9:0] exp_q[$];

  // Model: phase name, cycles spent in the phase, latched cause.
  int m_state = 0;
  int m_cnt   = 0;
  int m_code  = 0;

  function automatic logic [9:0] model_outputs();
    logic g1, an, rn, ft;
    g1 = (m_state >= 1 && m_state <= 4);
    an = (m_state == 2 || m_state == 3);
    rn = (m_state == 3);
    ft = (m_state == 5);
    return {3'(m_state), g1, an, rn, ft, 3'(m_code)};
  endfunction

  function automatic void model_reset();
    m_state = 0; m_cnt = 0; m_code = 0;
  endfunction

  function automatic void model_step(input logic st, sp, il, g1, an, clr);
    int ns = m_state;
    if (m_state == 0) begin
      if (st && il) ns = 1;
    end else if (m_state == 5) begin
      if (clr && il) begin ns = 0; m_code = 0; end
    end else if (!il) begin
      ns = 5; m_code = 1;
    end else if ((m_state == 2 || m_state == 3) && !g1) begin
      ns = 5; m_code = 4;
    end else if (m_state == 3 && !an) begin
      ns = 5; m_code = 5;
    end else if (m_state == 4) begin
      if (m_cnt == OFD - 1) ns = 0;
    end else if (sp) begin
      ns = 4;
    end else if (m_state == 1) begin
      if (g1) ns = 2;
      else if (m_cnt == G1T - 1) begin ns = 5; m_code = 2; end
    end else if (m_state == 2) begin
      if (an) ns = 3;
      else if (m_cnt == ANT - 1) begin ns = 5; m_code = 3; end
    end
    if (ns != m_state) m_cnt = 0;
    else if (m_state == 1 || m_state == 2 || m_state == 4) m_cnt++;
    m_state = ns;
  endfunction

  // Drive one cycle of inputs, queue the expectation, return just after the edge.
  task automatic step(input logic st, sp, il, g1, an, clr);
    @(negedge clk);
    start = st; stop = sp; interlock_ok = il; g1_ok = g1; an_ok = an; fault_clr = clr;
    if (!reset) model_reset();
    else model_step(st, sp, il, g1, an, clr);
    exp_q.push_back(model_outputs());
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Monitor: compare every clocked output against the queued expectation.
  initial begin : monitor
    logic [9:0] e, g;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {state, g1_en, an_en, running, fault, fault_code};
        checks++;
        if (g !== e) begin
          failures++;
          $display("FAIL cycle%0d outputs: got st=%0d g1=%b an=%b run=%b flt=%b code=%b expected st=%0d g1=%b an=%b run=%b flt=%b code=%b",
                   cyc, g[9:7], g[6], g[5], g[4], g[3], g[2:0],
                   e[9:7], e[6], e[5], e[4], e[3], e[2:0]);
        end
      end
    end
  end

  task automatic to_run();
    step(1, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 1, 0);
  endtask

  task automatic async_reset_check(input string name);
    reset = 1'b0;
    model_reset();
    #1;
    chk({name, "_g1_en"}, int'(g1_en), 0);
    chk({name, "_an_en"}, int'(an_en), 0);
    chk({name, "_state"}, int'(state), 0);
    chk({name, "_code"}, int'(fault_code), 0);
  endtask

  initial begin : stim
    int n;
    logic g1s, ans, rst_hold;
    #3;
    chk("reset_state", int'(state), 0);
    chk("reset_fault", int'(fault), 0);
    step(1, 0, 1, 1, 1, 0);
    step(1, 0, 1, 1, 1, 0);
    reset = 1'b1;

    // Nominal power-up
    step(1, 0, 1, 0, 0, 0);
    chk("nom_g1_ramp", int'(state), 1);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    chk("nom_an_ramp", int'(state), 2);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 1, 0);
    chk("nom_run", int'(state), 3);
    chk("nom_running", int'(running), 1);
    chk("nom_an_en", int'(an_en), 1);

    // Orderly stop
    step(0, 1, 1, 1, 1, 0);
    chk("stop_an_en", int'(an_en), 0);
    chk("stop_g1_en", int'(g1_en), 1);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 1, 1, 1, 0);
      if (state != 3'd4) break;
      n++;
    end
    chk("stop_g1_hold_cycles", n, 4);
    chk("stop_idle", int'(state), 0);

    // G1 timeout
    step(1, 0, 1, 0, 0, 0);
    n = 1;
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 1, 0, 0, 0);
      if (state != 3'd1) break;
      n++;
    end
    chk("g1tmo_cycles", n, 8);
    chk("g1tmo_state", int'(state), 5);
    chk("g1tmo_code", int'(fault_code), 2);
    chk("g1tmo_g1_en", int'(g1_en), 0);
    step(1, 0, 1, 0, 0, 0);
    chk("fault_ignores_start", int'(state), 5);
    step(0, 0, 1, 0, 0, 1);
    chk("clr_idle", int'(state), 0);
    chk("clr_code", int'(fault_code), 0);

    // Interlock loss beats stop
    to_run();
    step(0, 1, 0, 1, 1, 0);
    chk("intlk_state", int'(state), 5);
    chk("intlk_code", int'(fault_code), 1);
    step(0, 0, 0, 1, 1, 1);
    chk("intlk_clr_blocked", int'(state), 5);
    step(0, 0, 1, 1, 1, 1);
    chk("intlk_clr_ok", int'(state), 0);

    // an_ok arriving on the last AN_RAMP cycle advances
    step(1, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < ANT - 1; i++) step(0, 0, 1, 1, 0, 0);
    chk("an_late_still_ramp", int'(state), 2);
    step(0, 0, 1, 1, 1, 0);
    chk("an_late_run", int'(state), 3);
    chk("an_late_no_fault", int'(fault), 0);

    // Async reset in AN_RAMP
    step(0, 1, 1, 1, 1, 0);
    for (int i = 0; i < OFD; i++) step(0, 0, 1, 1, 1, 0);
    step(1, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    chk("pre_rst_an_ramp", int'(state), 2);
    async_reset_check("async_rst");
    step(1, 0, 1, 1, 1, 0);
    step(1, 0, 1, 1, 1, 0);
    reset = 1'b1;
    step(0, 0, 1, 1, 1, 0);
    chk("post_rst_idle", int'(state), 0);

    // Randomised run with sticky supply health and occasional resets
    g1s = 1'b1; ans = 1'b1; rst_hold = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(11) == 0) g1s = ~g1s;
      if ($urandom_range(9) == 0)  ans = ~ans;
      if (rst_hold) begin
        reset = 1'b1;
        rst_hold = 1'b0;
      end else if ($urandom_range(249) == 0) begin
        async_reset_check("rand_rst");
        rst_hold = 1'b1;
      end
      step(1'($urandom_range(3) == 0), 1'($urandom_range(23) == 0),
           1'($urandom_range(39) != 0), g1s, ans, 1'($urandom_range(2) == 0));
    end
    reset = 1'b1;
    step(0, 0, 1, 1, 1, 0);
    #2;
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rpsc_hv_sequencer.md
RPSC_HV_SEQUENCER -- requirements
Module: rpsc_hv_sequencer

Interface
REQ-001 The block SHALL have the following parameter: CNT_WIDTH, default 22, width of the shared phase counter.
REQ-002 The block SHALL have the following parameter: G1_TIMEOUT, default 1562500, G1 ramp limit in clk cycles (2 s at 1.28 us).
REQ-003 The block SHALL have the following parameter: AN_TIMEOUT, default 3125000, anode ramp limit in clk cycles (4 s).
REQ-004 The block SHALL have the following parameter: OFF_DELAY, default 781250, G1 hold time after anode off in clk cycles (1 s).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-007 The block SHALL have port start, input, 1 bit: level request to power up the HV chain.
REQ-008 The block SHALL have port stop, input, 1 bit: level request for an orderly power down.
REQ-009 The block SHALL have port interlock_ok, input, 1 bit: 1 = all card alarm/permissive chains are healthy.
REQ-010 The block SHALL have port g1_ok, input, 1 bit: G1 supply is up and within limits.
REQ-011 The block SHALL have port an_ok, input, 1 bit: anode supply is up and within limits.
REQ-012 The block SHALL have port fault_clr, input, 1 bit: operator acknowledge of a latched fault.
REQ-013 The block SHALL have port g1_en, output, 1 bit: enable to the G1 supply.
REQ-014 The block SHALL have port an_en, output, 1 bit: enable to the anode supply.
REQ-015 The block SHALL have port running, output, 1 bit: 1 = the sequence is complete and the chain is on.
REQ-016 The block SHALL have port fault, output, 1 bit: 1 = a fault is latched.
REQ-017 The block SHALL have port fault_code, output, 3 bits: cause of the latched fault.
REQ-018 The block SHALL have port state, output, 3 bits: current state code.

Function
REQ-019 States SHALL be encoded as IDLE=0, G1_RAMP=1, AN_RAMP=2, RUN=3, SHUTDOWN=4, FAULT=5; codes 6-7 SHALL return to FAULT with fault_code=111.
REQ-020 All outputs SHALL be registered (Moore); each input SHALL affect the state and outputs exactly one clk edge after it is sampled.
REQ-021 g1_en SHALL be 1 only in G1_RAMP, AN_RAMP, RUN and SHUTDOWN; an_en SHALL be 1 only in AN_RAMP and RUN; running SHALL be 1 only in RUN; fault SHALL be 1 only in FAULT.
REQ-022 The phase counter SHALL clear to 0 on every state entry, increment once per cycle in G1_RAMP, AN_RAMP and SHUTDOWN, and saturate at all-ones without wrapping.
REQ-023 In IDLE, start=1 with interlock_ok=1 SHALL move the block to G1_RAMP; start with interlock_ok=0 SHALL be ignored; stop SHALL have no effect.
REQ-024 In G1_RAMP, g1_ok=1 SHALL move the block to AN_RAMP.
REQ-025 In G1_RAMP, a counter value of G1_TIMEOUT-1 with g1_ok=0 SHALL move the block to FAULT with fault_code=010.
REQ-026 In AN_RAMP, an_ok=1 SHALL move the block to RUN; a counter value of AN_TIMEOUT-1 with an_ok=0 SHALL move the block to FAULT with fault_code=011.
REQ-027 In AN_RAMP or RUN, g1_ok=0 SHALL move the block to FAULT with fault_code=100; in RUN, an_ok=0 SHALL move the block to FAULT with fault_code=101.
REQ-028 In G1_RAMP, AN_RAMP or RUN, stop=1 SHALL move the block to SHUTDOWN: an_en drops at once, and g1_en is held until the counter reaches OFF_DELAY-1, then the block moves to IDLE.
REQ-029 In SHUTDOWN, start and stop SHALL be ignored.
REQ-030 interlock_ok=0 in any state other than IDLE or FAULT SHALL move the block to FAULT with fault_code=001.
REQ-031 Transition priority SHALL be: interlock loss > supply loss (g1_ok/an_ok drop) > stop > ok-advance > timeout; an ok arriving on the timeout cycle SHALL advance, not fault.
REQ-032 On entry to FAULT, g1_en and an_en SHALL both drop on the same edge; fault_code SHALL latch the first cause and hold it.
REQ-033 In FAULT, fault_clr=1 with interlock_ok=1 SHALL move the block to IDLE and clear fault_code to 000; start SHALL be ignored while in FAULT.

Reset
REQ-034 While reset=0, regardless of clk: state=IDLE, counter=0, g1_en=0, an_en=0, running=0, fault=0, fault_code=000.
REQ-035 Reset asserted mid-sequence SHALL drop both enables immediately; after release the block SHALL wait in IDLE for a new start.

Verification (bench parameters G1_TIMEOUT=8, AN_TIMEOUT=15, OFF_DELAY=4)
REQ-036 Nominal: start=1, interlock_ok=1; g1_ok=1 three cycles later; an_ok=1 five cycles after that -> state 1->2->3, running=1, g1_en=an_en=1.
REQ-037 G1 timeout: start with g1_ok held 0 -> exactly 8 cycles in G1_RAMP, then FAULT with fault_code=010 and g1_en=0; fault_clr -> IDLE with fault_code=000.
REQ-038 Orderly stop: from RUN, pulse stop -> an_en=0 on the next edge, g1_en=1 for 4 cycles, then IDLE.
REQ-039 Interlock loss: from RUN, interlock_ok=0 together with stop -> FAULT with fault_code=001, no SHUTDOWN; fault_clr with interlock_ok=0 -> remains in FAULT.
REQ-040 Edge cases: an_ok rising on the 15th AN_RAMP cycle -> RUN with no fault; reset=0 asserted in AN_RAMP -> enables 0 asynchronously, then IDLE after reset=1.
